// File: rtl/pci_target_burst_if.sv
// PCI target-side bus bundle: sampled inputs from the pad wrappers plus target drive values
// and output enables.
interface pci_target_burst_if;
    logic [31:0] AD_I;
    logic [31:0] AD_O;
    logic        OE_AD_N;
    logic [3:0]  CBE_I_N;
    logic        PAR_O;
    logic        OE_PAR_N;
    logic        FRAME_I_N;
    logic        IRDY_I_N;
    logic        IDSEL_I;
    logic        DEVSEL_O_N;
    logic        TRDY_O_N;
    logic        STOP_O_N;
    logic        OE_DEVSEL_N;
    logic        OE_TRDY_N;
    logic        OE_STOP_N;

    modport slave (
        input  AD_I, CBE_I_N, FRAME_I_N, IRDY_I_N, IDSEL_I,
        output AD_O, OE_AD_N, PAR_O, OE_PAR_N, DEVSEL_O_N, TRDY_O_N, STOP_O_N,
               OE_DEVSEL_N, OE_TRDY_N, OE_STOP_N
    );

    modport master (
        output AD_I, CBE_I_N, FRAME_I_N, IRDY_I_N, IDSEL_I,
        input  AD_O, OE_AD_N, PAR_O, OE_PAR_N, DEVSEL_O_N, TRDY_O_N, STOP_O_N,
               OE_DEVSEL_N, OE_TRDY_N, OE_STOP_N
    );
endinterface

// File: rtl/pci_target_burst.sv
// 33 MHz PCI target: Type-0 config space, IO BAR, prefetchable MEM BAR with linear bursts,
// byte-masked writes, disconnect at window end / burst limit, and a user read port into MEM.
module pci_target_burst #(
    parameter int          IO_WINDOW_BITS  = 4,
    parameter int          MEM_WINDOW_BITS = 8,
    parameter int          MAX_BURST       = 16,
    parameter logic [15:0] CFG_DEVICE      = 16'h0301,
    parameter logic [15:0] CFG_VENDOR      = 16'h10ee,
    parameter logic [15:0] CFG_CC          = 16'h0b40,
    parameter logic [15:0] CFG_REVISION    = 16'h0001
) (
    input  logic                       CLK,
    input  logic                       RST,
    pci_target_burst_if.slave          bus,
    input  logic [MEM_WINDOW_BITS-3:0] USR_ADDR,
    output logic [31:0]                USR_RDATA,
    output logic                       USR_WR,
    output logic [MEM_WINDOW_BITS-3:0] USR_WADDR
);
    localparam int MI   = MEM_WINDOW_BITS - 2;
    localparam int IOI  = IO_WINDOW_BITS - 2;
    localparam int IDXW = (MI > 6) ? MI : 6;
    localparam int BW   = $clog2(MAX_BURST + 1);
    localparam int NIO  = 2 ** IOI;
    localparam int NMEM = 2 ** MI;

    typedef enum logic [2:0] {S_IDLE, S_DEVSEL, S_XFER, S_STOP, S_TURN} state_t;
    typedef enum logic [1:0] {T_CFG, T_IO, T_MEM} acc_t;

    state_t r_state, w_next_state;
    acc_t   r_type;
    logic [IDXW-1:0] r_idx, w_next_idx;
    logic [BW-1:0]   r_bcnt;
    logic            r_rd, r_misal;
    logic            r_io_en, r_mem_en, r_intdis;
    logic [7:0]      r_intline;
    logic [31:IO_WINDOW_BITS]  r_bar0;
    logic [31:MEM_WINDOW_BITS] r_bar1;
    logic [31:0] r_io [NIO];
    logic [31:0] r_mem [NMEM];
    logic [31:0] r_ad, r_usr_rdata;
    logic        r_par, r_oe_par_n, r_usr_wr;
    logic [MI-1:0] r_usr_waddr;

    logic w_cfg_hit, w_io_hit, w_mem_hit, w_hit, w_done, w_wr, w_last;
    logic w_devsel_n, w_trdy_n, w_stop_n, w_oe_ctl_n, w_oe_ad_n;
    logic [31:0] w_rdata, w_cfg_rdata, w_wmerge_io, w_wmerge_mem, w_bar0_m, w_bar1_m;

    function automatic logic [31:0] f_merge(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] be_n);
        logic [31:0] v;
        for (int b = 0; b < 4; b++) v[8*b +: 8] = be_n[b] ? o[8*b +: 8] : n[8*b +: 8];
        return v;
    endfunction

    assign w_cfg_hit = bus.IDSEL_I && (bus.CBE_I_N[3:1] == 3'b101) &&
                       (bus.AD_I[1:0] == 2'b00) && (bus.AD_I[10:8] == 3'b000);
    assign w_io_hit  = (bus.CBE_I_N[3:1] == 3'b001) && r_io_en &&
                       (bus.AD_I[31:IO_WINDOW_BITS] == r_bar0) && (bus.AD_I[1:0] == 2'b00);
    assign w_mem_hit = (bus.CBE_I_N[3:1] == 3'b011) && r_mem_en &&
                       (bus.AD_I[31:MEM_WINDOW_BITS] == r_bar1);
    assign w_hit     = (r_state == S_IDLE) && !bus.FRAME_I_N && (w_cfg_hit || w_io_hit || w_mem_hit);

    assign w_done     = (r_state == S_XFER) && !bus.IRDY_I_N;
    assign w_wr       = w_done && !r_rd;
    assign w_next_idx = r_idx + {{(IDXW-1){1'b0}}, w_done};
    // Cfg/IO are single-phase; MEM stops at the window end so the index never wraps.
    assign w_last = (r_type != T_MEM) || (r_idx[MI-1:0] == {MI{1'b1}}) ||
                    (r_bcnt == BW'(MAX_BURST - 1)) || r_misal;

    assign w_wmerge_io  = f_merge(r_io[r_idx[IOI-1:0]], bus.AD_I, bus.CBE_I_N);
    assign w_wmerge_mem = f_merge(r_mem[r_idx[MI-1:0]], bus.AD_I, bus.CBE_I_N);
    assign w_bar0_m     = f_merge({r_bar0, {IO_WINDOW_BITS{1'b0}}}, bus.AD_I, bus.CBE_I_N);
    assign w_bar1_m     = f_merge({r_bar1, {MEM_WINDOW_BITS{1'b0}}}, bus.AD_I, bus.CBE_I_N);

    always_comb begin
        w_cfg_rdata = '0;
        case (w_next_idx[5:0])
            6'd0:  w_cfg_rdata = {CFG_DEVICE, CFG_VENDOR};
            6'd1:  w_cfg_rdata = {16'h0400, 5'b0, r_intdis, 8'b0, r_mem_en, r_io_en};
            6'd2:  w_cfg_rdata = {CFG_CC, CFG_REVISION};
            6'd4:  w_cfg_rdata = {r_bar0, {(IO_WINDOW_BITS-1){1'b0}}, 1'b1};
            6'd5:  w_cfg_rdata = {r_bar1, {(MEM_WINDOW_BITS-4){1'b0}}, 4'b1000};
            6'd15: w_cfg_rdata = {16'h0000, 8'h01, r_intline};
            default: w_cfg_rdata = '0;
        endcase
        case (r_type)
            T_IO:    w_rdata = r_io[w_next_idx[IOI-1:0]];
            T_MEM:   w_rdata = r_mem[w_next_idx[MI-1:0]];
            default: w_rdata = w_cfg_rdata;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_devsel_n   = 1'b1;
        w_trdy_n     = 1'b1;
        w_stop_n     = 1'b1;
        w_oe_ctl_n   = 1'b1;
        w_oe_ad_n    = 1'b1;
        case (r_state)
            S_IDLE: if (w_hit) w_next_state = S_DEVSEL;
            S_DEVSEL: begin
                w_devsel_n   = 1'b0;
                w_oe_ctl_n   = 1'b0;
                w_oe_ad_n    = !r_rd;
                w_next_state = S_XFER;
            end
            S_XFER: begin
                w_devsel_n = 1'b0;
                w_trdy_n   = 1'b0;
                w_stop_n   = !w_last;
                w_oe_ctl_n = 1'b0;
                w_oe_ad_n  = !r_rd;
                if (w_done) begin
                    if (bus.FRAME_I_N) w_next_state = S_TURN;
                    else if (w_last)   w_next_state = S_STOP;
                end
            end
            S_STOP: begin
                w_devsel_n = 1'b0;
                w_stop_n   = 1'b0;
                w_oe_ctl_n = 1'b0;
                if (bus.FRAME_I_N) w_next_state = S_TURN;
            end
            S_TURN: begin
                w_oe_ctl_n   = 1'b0;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_type      <= T_CFG;
            r_idx       <= '0;
            r_bcnt      <= '0;
            r_rd        <= 1'b0;
            r_misal     <= 1'b0;
            r_io_en     <= 1'b0;
            r_mem_en    <= 1'b0;
            r_intdis    <= 1'b0;
            r_intline   <= '0;
            r_bar0      <= '0;
            r_bar1      <= '0;
            r_ad        <= '0;
            r_par       <= 1'b0;
            r_oe_par_n  <= 1'b1;
            r_usr_wr    <= 1'b0;
            r_usr_waddr <= '0;
            r_usr_rdata <= '0;
            for (int k = 0; k < NIO; k++) r_io[k] <= '0;
        end else begin
            r_par       <= ^{r_ad, bus.CBE_I_N};
            r_oe_par_n  <= w_oe_ad_n;
            r_usr_rdata <= r_mem[USR_ADDR];
            r_usr_wr    <= w_wr && (r_type == T_MEM);
            r_usr_waddr <= r_idx[MI-1:0];
            if (r_state == S_DEVSEL || r_state == S_XFER) r_ad <= w_rdata;
            if (w_hit) begin
                r_rd    <= !bus.CBE_I_N[0];
                r_bcnt  <= '0;
                r_misal <= 1'b0;
                if (w_cfg_hit) begin
                    r_type <= T_CFG;
                    r_idx  <= IDXW'(bus.AD_I[7:2]);
                end else if (w_io_hit) begin
                    r_type <= T_IO;
                    r_idx  <= IDXW'(bus.AD_I[IO_WINDOW_BITS-1:2]);
                end else begin
                    r_type  <= T_MEM;
                    r_idx   <= IDXW'(bus.AD_I[MEM_WINDOW_BITS-1:2]);
                    r_misal <= (bus.AD_I[1:0] != 2'b00);
                end
            end
            if (w_done) begin
                r_idx  <= w_next_idx;
                r_bcnt <= r_bcnt + 1'b1;
            end
            if (w_wr && r_type == T_IO) r_io[r_idx[IOI-1:0]] <= w_wmerge_io;
            if (w_wr && r_type == T_CFG) begin
                case (r_idx[5:0])
                    6'd1: begin
                        if (!bus.CBE_I_N[0]) {r_mem_en, r_io_en} <= bus.AD_I[1:0];
                        if (!bus.CBE_I_N[1]) r_intdis <= bus.AD_I[10];
                    end
                    6'd4:  r_bar0 <= w_bar0_m[31:IO_WINDOW_BITS];
                    6'd5:  r_bar1 <= w_bar1_m[31:MEM_WINDOW_BITS];
                    6'd15: if (!bus.CBE_I_N[0]) r_intline <= bus.AD_I[7:0];
                    default: ;
                endcase
            end
        end
    end

    // MEM array is deliberately outside the reset domain; reset only blocks writes.
    always_ff @(posedge CLK) begin
        if (!RST && w_wr && r_type == T_MEM) r_mem[r_idx[MI-1:0]] <= w_wmerge_mem;
    end

    assign bus.AD_O        = r_ad;
    assign bus.OE_AD_N     = w_oe_ad_n;
    assign bus.PAR_O       = r_par;
    assign bus.OE_PAR_N    = r_oe_par_n;
    assign bus.DEVSEL_O_N  = w_devsel_n;
    assign bus.TRDY_O_N    = w_trdy_n;
    assign bus.STOP_O_N    = w_stop_n;
    assign bus.OE_DEVSEL_N = w_oe_ctl_n;
    assign bus.OE_TRDY_N   = w_oe_ctl_n;
    assign bus.OE_STOP_N   = w_oe_ctl_n;
    assign USR_RDATA       = r_usr_rdata;
    assign USR_WR          = r_usr_wr;
    assign USR_WADDR       = r_usr_waddr;
endmodule

// File: tb/tb_pci_target_burst.sv
// Directed bench for pci_target_burst: table of single-phase cfg/IO transactions plus
// hand-written MEM burst, disconnect and reset sequences.
module tb_pci_target_burst;
    logic       CLK = 1'b0;
    logic       RST;
    logic [5:0] USR_ADDR;
    logic [31:0] USR_RDATA;
    logic       USR_WR;
    logic [5:0] USR_WADDR;

    pci_target_burst_if bus();

    pci_target_burst dut (
        .CLK(CLK), .RST(RST), .bus(bus.slave),
        .USR_ADDR(USR_ADDR), .USR_RDATA(USR_RDATA), .USR_WR(USR_WR), .USR_WADDR(USR_WADDR)
    );

    always #15 CLK = ~CLK;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] addr;
        logic        idsel;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        hit;
        logic [31:0] rdata;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] wr_buf [32];
    logic [3:0]  wr_be  [32];
    logic [31:0] rd_buf [32];
    logic [31:0] exp_rd [32];
    logic [31:0] exp_mem [64];
    logic [5:0]  wlog [$];

    always @(negedge CLK) if (USR_WR) wlog.push_back(USR_WADDR);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic all_oe_off();
        return bus.OE_AD_N & bus.OE_PAR_N & bus.OE_DEVSEL_N & bus.OE_TRDY_N & bus.OE_STOP_N;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be_n);
        logic [31:0] v;
        for (int b = 0; b < 4; b++) v[8*b +: 8] = be_n[b] ? o[8*b +: 8] : n[8*b +: 8];
        return v;
    endfunction

    // Master-side transaction: nph phases wanted, wmask bit p inserts one IRDY wait on phase p.
    task automatic xact(input logic [3:0] cmd, input logic [31:0] addr, input logic idsel,
                        input int nph, input logic [31:0] wmask,
                        output logic hit, output int ndone, output int stop_ph,
                        output logic turn_ok, output logic idle_ok);
        logic rd, irdy, frame_n, comp, last, term, done, waited, par_exp, trdy, stp;
        int p, cyc;
        rd = ~cmd[0];
        ndone = 0; stop_ph = -1; turn_ok = 0; idle_ok = 0;
        p = 0; cyc = 0; waited = 0; term = 0; done = 0; par_exp = 0; last = 0;
        @(posedge CLK); #1;
        bus.FRAME_I_N = 0; bus.IRDY_I_N = 1; bus.AD_I = addr; bus.CBE_I_N = cmd; bus.IDSEL_I = idsel;
        @(posedge CLK); #1;
        bus.IDSEL_I = 0;
        hit = (bus.DEVSEL_O_N == 1'b0) && (bus.OE_DEVSEL_N == 1'b0);
        if (!hit) begin
            idle_ok = all_oe_off();
            bus.FRAME_I_N = 1; bus.AD_I = 0; bus.CBE_I_N = 0;
            @(posedge CLK); #1;
            return;
        end
        while (!done && cyc < 200) begin
            cyc++;
            trdy = bus.TRDY_O_N; stp = bus.STOP_O_N; comp = 0; last = 0;
            if (term) begin
                bus.FRAME_I_N = 1; bus.IRDY_I_N = 1; done = 1;
            end else begin
                irdy = 0;
                if (wmask[p] && !waited) begin irdy = 1; waited = 1; end
                frame_n = !irdy && (p == nph - 1);
                bus.IRDY_I_N = irdy; bus.FRAME_I_N = frame_n;
                bus.AD_I    = rd ? 32'h0 : wr_buf[p];
                bus.CBE_I_N = rd ? 4'h0 : wr_be[p];
                comp = !trdy && !irdy;
                if (comp) begin
                    if (rd) begin
                        rd_buf[p] = bus.AD_O;
                        par_exp = ^{exp_rd[p], bus.CBE_I_N};
                    end
                    if (!stp && stop_ph < 0) stop_ph = p;
                    last = frame_n;
                    term = !stp && !frame_n;
                    ndone++; waited = 0;
                    if (p < 31) p++;
                end
            end
            @(posedge CLK); #1;
            if (comp && rd) begin
                chk("parity", 32'(bus.PAR_O), 32'(par_exp));
                chk("oe_par", 32'(bus.OE_PAR_N), 32'd0);
            end
            if (comp && last) begin bus.IRDY_I_N = 1; done = 1; end
        end
        if (!done) begin
            n_vec++; n_bad++;
            $display("FAIL xact_timeout: got no termination expected termination within 200 cycles");
        end
        turn_ok = (bus.DEVSEL_O_N == 1'b1) && (bus.TRDY_O_N == 1'b1) && (bus.STOP_O_N == 1'b1) &&
                  (bus.OE_DEVSEL_N == 1'b0) && (bus.OE_TRDY_N == 1'b0) && (bus.OE_STOP_N == 1'b0);
        bus.FRAME_I_N = 1; bus.IRDY_I_N = 1; bus.AD_I = 0; bus.CBE_I_N = 0;
        @(posedge CLK); #1;
        idle_ok = all_oe_off();
    endtask

    initial begin
        logic hit, tok, iok;
        int nd, sp;

        vecs[0]  = '{4'hA, 32'h0000_0000, 1'b1, 32'h0,         4'h0, 1'b1, 32'h0301_10ee};
        vecs[1]  = '{4'hA, 32'h0000_0008, 1'b1, 32'h0,         4'h0, 1'b1, 32'h0b40_0001};
        vecs[2]  = '{4'hA, 32'h0000_0004, 1'b1, 32'h0,         4'h0, 1'b1, 32'h0400_0000};
        vecs[3]  = '{4'hA, 32'h0000_003C, 1'b1, 32'h0,         4'h0, 1'b1, 32'h0000_0100};
        vecs[4]  = '{4'hB, 32'h0000_0010, 1'b1, 32'hFFFF_FFFF, 4'h0, 1'b1, 32'h0};
        vecs[5]  = '{4'hA, 32'h0000_0010, 1'b1, 32'h0,         4'h0, 1'b1, 32'hFFFF_FFF1};
        vecs[6]  = '{4'hB, 32'h0000_0014, 1'b1, 32'hFFFF_FFFF, 4'h0, 1'b1, 32'h0};
        vecs[7]  = '{4'hA, 32'h0000_0014, 1'b1, 32'h0,         4'h0, 1'b1, 32'hFFFF_FF08};
        vecs[8]  = '{4'h2, 32'hFFFF_FFF0, 1'b0, 32'h0,         4'h0, 1'b0, 32'h0};
        vecs[9]  = '{4'hA, 32'h0000_0000, 1'b0, 32'h0,         4'h0, 1'b0, 32'h0};
        vecs[10] = '{4'hA, 32'h0000_0100, 1'b1, 32'h0,         4'h0, 1'b0, 32'h0};
        vecs[11] = '{4'hB, 32'h0000_0010, 1'b1, 32'h0000_1000, 4'h0, 1'b1, 32'h0};
        vecs[12] = '{4'hB, 32'h0000_0014, 1'b1, 32'h2000_0000, 4'h0, 1'b1, 32'h0};
        vecs[13] = '{4'hB, 32'h0000_0004, 1'b1, 32'hFFFF_0403, 4'h0, 1'b1, 32'h0};
        vecs[14] = '{4'hA, 32'h0000_0004, 1'b1, 32'h0,         4'h0, 1'b1, 32'h0400_0403};
        vecs[15] = '{4'hB, 32'h0000_003C, 1'b1, 32'h1234_5678, 4'h0, 1'b1, 32'h0};
        vecs[16] = '{4'hA, 32'h0000_003C, 1'b1, 32'h0,         4'h0, 1'b1, 32'h0000_0178};
        vecs[17] = '{4'hB, 32'h0000_000C, 1'b1, 32'hFFFF_FFFF, 4'h0, 1'b1, 32'h0};
        vecs[18] = '{4'hA, 32'h0000_000C, 1'b1, 32'h0,         4'h0, 1'b1, 32'h0};
        vecs[19] = '{4'h3, 32'h0000_1004, 1'b0, 32'hA5A5_5A5A, 4'h0, 1'b1, 32'h0};
        vecs[20] = '{4'h2, 32'h0000_1004, 1'b0, 32'h0,         4'h0, 1'b1, 32'hA5A5_5A5A};
        vecs[21] = '{4'h3, 32'h0000_1004, 1'b0, 32'h1111_1111, 4'h5, 1'b1, 32'h0};
        vecs[22] = '{4'h2, 32'h0000_1004, 1'b0, 32'h0,         4'h0, 1'b1, 32'h11A5_115A};
        vecs[23] = '{4'h2, 32'h0000_1006, 1'b0, 32'h0,         4'h0, 1'b0, 32'h0};
        vecs[24] = '{4'h2, 32'h0000_1010, 1'b0, 32'h0,         4'h0, 1'b0, 32'h0};
        vecs[25] = '{4'hB, 32'h0000_0004, 1'b1, 32'h0000_0000, 4'hD, 1'b1, 32'h0};
        vecs[26] = '{4'hA, 32'h0000_0004, 1'b1, 32'h0,         4'h0, 1'b1, 32'h0400_0003};
        vecs[27] = '{4'h2, 32'h0000_1000, 1'b0, 32'h0,         4'h0, 1'b1, 32'h0};

        RST = 1; USR_ADDR = 0;
        bus.AD_I = 0; bus.CBE_I_N = 0; bus.FRAME_I_N = 1; bus.IRDY_I_N = 1; bus.IDSEL_I = 0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_oe", 32'(all_oe_off()), 32'd1);
        chk("rst_ctl", {29'd0, bus.DEVSEL_O_N, bus.TRDY_O_N, bus.STOP_O_N}, 32'd7);
        chk("rst_ad", bus.AD_O, 32'd0);
        chk("rst_par", 32'(bus.PAR_O), 32'd0);
        chk("rst_usr", {31'd0, USR_WR} | USR_RDATA, 32'd0);
        RST = 0;

        for (int i = 0; i < NV; i++) begin
            wr_buf[0] = vecs[i].wdata; wr_be[0] = vecs[i].be; exp_rd[0] = vecs[i].rdata;
            xact(vecs[i].cmd, vecs[i].addr, vecs[i].idsel, 1, 32'h0, hit, nd, sp, tok, iok);
            chk($sformatf("v%0d_hit", i), 32'(hit), 32'(vecs[i].hit));
            if (vecs[i].hit) begin
                chk($sformatf("v%0d_ndone", i), 32'(nd), 32'd1);
                chk($sformatf("v%0d_stop", i), 32'(sp), 32'd0);
                chk($sformatf("v%0d_turn", i), 32'(tok), 32'd1);
                if (!vecs[i].cmd[0]) chk($sformatf("v%0d_data", i), rd_buf[0], vecs[i].rdata);
            end else begin
                chk($sformatf("v%0d_idle", i), 32'(iok), 32'd1);
            end
        end

        // 16-dword write from index 0: burst limit forces STOP on phase 15.
        for (int i = 0; i < 16; i++) begin
            wr_buf[i] = 32'h5A00_0000 + i * 32'h0001_0203; wr_be[i] = 4'h0;
            exp_mem[i] = wr_buf[i];
        end
        xact(4'h7, 32'h2000_0000, 1'b0, 16, 32'h0, hit, nd, sp, tok, iok);
        chk("w16_ndone", 32'(nd), 32'd16);
        chk("w16_stop", 32'(sp), 32'd15);
        chk("w16_turn", 32'(tok), 32'd1);

        // Masked 4-dword write: dword 2 updates only lanes 0-1.
        for (int i = 0; i < 4; i++) begin
            wr_buf[i] = 32'hA0B0_C0D0 + i;
            wr_be[i]  = (i == 2) ? 4'hC : 4'h0;
            exp_mem[i] = merge(exp_mem[i], wr_buf[i], wr_be[i]);
        end
        wlog.delete();
        xact(4'h7, 32'h2000_0000, 1'b0, 4, 32'h0, hit, nd, sp, tok, iok);
        chk("w4_ndone", 32'(nd), 32'd4);
        chk("w4_nostop", 32'(sp), 32'hFFFF_FFFF);
        chk("w4_nwr", 32'(wlog.size()), 32'd4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) chk($sformatf("w4_waddr%0d", i), 32'(wlog[i]), 32'(i));
        chk("w4_dw2_model", exp_mem[2], 32'h5A02_C0D2);
        USR_ADDR = 6'd2;
        @(posedge CLK); #1;
        chk("usr_rd2", USR_RDATA, exp_mem[2]);

        // 20-phase read with waits on phases 3 and 7: disconnect after 16.
        for (int i = 0; i < 16; i++) exp_rd[i] = exp_mem[i];
        xact(4'h6, 32'h2000_0000, 1'b0, 20, 32'h0000_0088, hit, nd, sp, tok, iok);
        chk("r20_ndone", 32'(nd), 32'd16);
        chk("r20_stop", 32'(sp), 32'd15);
        chk("r20_turn", 32'(tok), 32'd1);
        for (int i = 0; i < 16; i++) chk($sformatf("r20_data%0d", i), rd_buf[i], exp_mem[i]);

        // Write at the last window dword: one phase then disconnect-with-data.
        wr_buf[0] = 32'h0BAD_F00D; wr_be[0] = 4'h0; exp_mem[63] = wr_buf[0];
        wlog.delete();
        xact(4'h7, 32'h2000_00FC, 1'b0, 3, 32'h0, hit, nd, sp, tok, iok);
        chk("wlast_ndone", 32'(nd), 32'd1);
        chk("wlast_stop", 32'(sp), 32'd0);
        chk("wlast_turn", 32'(tok), 32'd1);
        chk("wlast_idle", 32'(iok), 32'd1);
        chk("wlast_nwr", 32'(wlog.size()), 32'd1);
        if (wlog.size() > 0) chk("wlast_waddr", 32'(wlog[0]), 32'd63);

        // Misaligned MEM address: single phase with STOP.
        exp_rd[0] = exp_mem[4];
        xact(4'h6, 32'h2000_0011, 1'b0, 4, 32'h0, hit, nd, sp, tok, iok);
        chk("mis_ndone", 32'(nd), 32'd1);
        chk("mis_stop", 32'(sp), 32'd0);
        chk("mis_data", rd_buf[0], exp_mem[4]);

        // Reset in the middle of a read burst.
        @(posedge CLK); #1;
        bus.FRAME_I_N = 0; bus.AD_I = 32'h2000_0000; bus.CBE_I_N = 4'h6;
        @(posedge CLK); #1;
        bus.CBE_I_N = 0; bus.AD_I = 0; bus.IRDY_I_N = 0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("pre_rst_trdy", 32'(bus.TRDY_O_N), 32'd0);
        RST = 1;
        @(posedge CLK); #1;
        chk("mid_rst_oe", 32'(all_oe_off()), 32'd1);
        chk("mid_rst_ctl", {29'd0, bus.DEVSEL_O_N, bus.TRDY_O_N, bus.STOP_O_N}, 32'd7);
        chk("mid_rst_ad", bus.AD_O, 32'd0);
        RST = 0; bus.FRAME_I_N = 1; bus.IRDY_I_N = 1;
        @(posedge CLK); #1;
        chk("post_rst_idle", 32'(all_oe_off()), 32'd1);
        exp_rd[0] = 32'h0000_0001;
        xact(4'hA, 32'h0000_0010, 1'b1, 1, 32'h0, hit, nd, sp, tok, iok);
        chk("rst_bar0", rd_buf[0], 32'h0000_0001);
        exp_rd[0] = 32'h0000_0008;
        xact(4'hA, 32'h0000_0014, 1'b1, 1, 32'h0, hit, nd, sp, tok, iok);
        chk("rst_bar1", rd_buf[0], 32'h0000_0008);
        exp_rd[0] = 32'h0400_0000;
        xact(4'hA, 32'h0000_0004, 1'b1, 1, 32'h0, hit, nd, sp, tok, iok);
        chk("rst_cmd", rd_buf[0], 32'h0400_0000);
        USR_ADDR = 6'd5;
        @(posedge CLK); #1;
        chk("mem_kept", USR_RDATA, exp_mem[5]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
